// File: rtl/pipelined_ripple_subtractor.sv
// Pipelined WIDTH-bit subtractor (Diff = A - B - bin), one SEG-bit ripple-borrow segment per stage.
// A single global advance moves every stage at once; Bout/Ovf/Zero are presented alongside Diff.
module pipelined_ripple_subtractor #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int SEG_SAFE = (SEG >= 1) ? SEG : 1;
  localparam int STAGES   = WIDTH / SEG_SAFE;

  if (SEG < 1 || (WIDTH % SEG_SAFE) != 0 || STAGES < 1) begin : g_param_check
    $fatal(1, "pipelined_ripple_subtractor: WIDTH must be a positive multiple of SEG");
  end

  logic w_adv;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [SEG-1:0] w_a_seg;
    logic [SEG-1:0] w_b_seg;
    logic [SEG-1:0] w_seg;
    logic           w_bin;
    logic           w_v_in;
    logic           w_bout;
    logic [HI-1:0]  w_d_nxt;
    logic [HI-1:0]  r_d;
    logic           r_bo;
    logic           r_v;

    // Stage k takes its segment and borrow from the registers of stage k-1; lower Diff bits ride along.
    if (k == 0) begin : g_src
      assign w_a_seg = A[LO +: SEG];
      assign w_b_seg = B[LO +: SEG];
      assign w_bin   = bin;
      assign w_v_in  = in_valid;
      assign w_d_nxt = w_seg;
    end else begin : g_src
      assign w_a_seg = g_st[k-1].g_ab.r_a[LO +: SEG];
      assign w_b_seg = g_st[k-1].g_ab.r_b[LO +: SEG];
      assign w_bin   = g_st[k-1].r_bo;
      assign w_v_in  = g_st[k-1].r_v;
      assign w_d_nxt = {w_seg, g_st[k-1].r_d};
    end

    always_comb begin
      logic w_chain;
      w_chain = w_bin;
      w_seg   = '0;
      for (int i = 0; i < SEG; i++) begin
        w_seg[i] = w_a_seg[i] ^ w_b_seg[i] ^ w_chain;
        w_chain  = (~w_a_seg[i] & w_b_seg[i]) | (~(w_a_seg[i] ^ w_b_seg[i]) & w_chain);
      end
      w_bout = w_chain;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v  <= 1'b0;
        r_bo <= 1'b0;
        r_d  <= '0;
      end else if (w_adv) begin
        r_v  <= w_v_in;
        r_bo <= w_bout;
        r_d  <= w_d_nxt;
      end
    end

    // Operand bits not yet consumed are delayed so they meet their borrow at the right stage.
    if (k < STAGES - 1) begin : g_ab
      logic [WIDTH-1:HI] w_a_up;
      logic [WIDTH-1:HI] w_b_up;
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;

      if (k == 0) begin : g_up
        assign w_a_up = A[WIDTH-1:HI];
        assign w_b_up = B[WIDTH-1:HI];
      end else begin : g_up
        assign w_a_up = g_st[k-1].g_ab.r_a[WIDTH-1:HI];
        assign w_b_up = g_st[k-1].g_ab.r_b[WIDTH-1:HI];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic r_ovf;
      logic r_zero;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b1;
        end else if (w_adv) begin
          r_ovf  <= (w_a_seg[SEG-1] ^ w_b_seg[SEG-1]) & (w_seg[SEG-1] ^ w_a_seg[SEG-1]);
          r_zero <= (w_d_nxt == '0);
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign Diff      = g_st[STAGES-1].r_d;
  assign Bout      = g_st[STAGES-1].r_bo;
  assign Ovf       = g_st[STAGES-1].g_flags.r_ovf;
  assign Zero      = g_st[STAGES-1].g_flags.r_zero;

endmodule

// File: tb/tb_pipelined_ripple_subtractor.sv
// Scoreboard bench for pipelined_ripple_subtractor (WIDTH=16, SEG=4): driver queues expected
// results on each accepted beat; a negedge monitor checks every presented result in order.
module tb_pipelined_ripple_subtractor;
  localparam int STAGES = 4;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    int          tcyc;
    bit          chk;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Diff;
  logic        Bout;
  logic        Ovf;
  logic        Zero;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t e_m;

  pipelined_ripple_subtractor #(.WIDTH(16), .SEG(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Bout     (Bout),
    .Ovf      (Ovf),
    .Zero     (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov, input logic z,
                              input bit chk);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov; e.z = z; e.tcyc = 0; e.chk = chk;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                                 input bit chk);
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - {16'b0, bi};
    return mk(r[15:0], r[16], (a[15] != b[15]) && (r[15] != a[15]), r[15:0] == 16'h0, chk);
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi, input exp_t e);
    int n;
    n = 0;
    A = a; B = b; bin = bi; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
    end else begin
      e.tcyc = cyc + STAGES;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    idle(2);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_valid=1 Diff=%h, required no result", Diff);
      end else begin
        e_m = q[0];
        checks++;
        if ({Diff, Bout, Ovf, Zero} !== {e_m.d, e_m.bo, e_m.ov, e_m.z}) begin
          errors++;
          $display("FAIL result: got Diff=%h Bout=%b Ovf=%b Zero=%b required Diff=%h Bout=%b Ovf=%b Zero=%b",
                   Diff, Bout, Ovf, Zero, e_m.d, e_m.bo, e_m.ov, e_m.z);
        end
        if (e_m.chk) begin
          checks++;
          if (cyc != e_m.tcyc) begin
            errors++;
            $display("FAIL latency: got cycle %0d required cycle %0d", cyc, e_m.tcyc);
          end
          q[0].chk = 1'b0;
        end
        if (!out_ready) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b required 0", in_ready);
          end
        end else begin
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        sc [8];

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_in_ready",  16'(in_ready),  16'h1);
    check("rst_diff",      Diff,           16'h0);
    check("rst_bout",      16'(Bout),      16'h0);
    check("rst_ovf",       16'(Ovf),       16'h0);
    check("rst_zero",      16'(Zero),      16'h1);
    rst = 1'b0;
    idle(1);

    // Directed vectors, back to back.
    send(16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1));
    send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
    send(16'h000F, 16'h000F, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1));
    send(16'hABCD, 16'hABCD, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1));
    send(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
    send(16'hFFFF, 16'hFFFF, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1));
    drain();

    // Eight-beat stream with a three-cycle output stall in the middle.
    sa = '{16'h1111, 16'hFFFF, 16'h8000, 16'h0001, 16'h5A5A, 16'h7FFF, 16'h0100, 16'hC3C3};
    sb = '{16'h2222, 16'h0000, 16'h7FFF, 16'h0001, 16'hA5A5, 16'h8000, 16'h00FF, 16'h3C3C};
    sc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    fork
      begin
        for (int i = 0; i < 8; i++) send(sa[i], sb[i], sc[i], model(sa[i], sb[i], sc[i], 1'b0));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset while three beats are in flight: none may surface afterwards.
    send(16'h4444, 16'h1111, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0, 1'b1));
    send(16'h0010, 16'h0020, 1'b0, mk(16'hFFF0, 1'b1, 1'b0, 1'b0, 1'b1));
    send(16'h9999, 16'h9999, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1));
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'h0);
    check("midrst_in_ready",  16'(in_ready),  16'h1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_stale", 16'(out_valid), 16'h0);
    end
    send(16'h2000, 16'h0001, 1'b1, mk(16'h1FFE, 1'b0, 1'b0, 1'b0, 1'b1));
    drain();

    // Bubbles: valid pattern 1,0,1,0,1,0.
    for (int i = 0; i < 3; i++) begin
      send(16'h0F00 + 16'(i), 16'h00F0, 1'b0, model(16'h0F00 + 16'(i), 16'h00F0, 1'b0, 1'b1));
      idle(1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
